// File: rtl/ram16x8_stream_reader.sv
`timescale 1ns/1ps
// ram16x8_stream_reader
//
// Read-side engine for a 16x8 distributed RAM (synchronous write, asynchronous
// read). Accepts a burst command (start address, length), walks the RAM read
// address with modulo-2**AW wrap and streams the bytes out on a valid/ready
// interface at up to one byte per cycle. The write side of the RAM lives
// elsewhere.
//
// Optional build macro: RAM16X8_STREAM_READER_CSUM_EN
//   When defined, a running XOR of all data beats is kept. One extra beat
//   carrying that XOR follows the data beats and is the only beat marked LAST.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   CMD_VAL    command valid
//   CMD_RDY    command ready, high only while idle
//   CMD_ADDR   burst start address
//   CMD_LEN    burst length; 0 encodes 2**AW
//   ABORT      synchronous burst cancel, ignored while idle
//   RADR       RAM read address (registered)
//   RDATA      RAM combinational read data
//   DOUT       stream data
//   DOUT_VAL   stream valid
//   DOUT_RDY   stream ready
//   DOUT_LAST  final beat of a burst
//   BUSY       high whenever not idle
module ram16x8_stream_reader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CMD_VAL,
  output logic          CMD_RDY,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [AW-1:0] CMD_LEN,
  input  logic          ABORT,
  output logic [AW-1:0] RADR,
  input  logic [DW-1:0] RDATA,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VAL,
  input  logic          DOUT_RDY,
  output logic          DOUT_LAST,
  output logic          BUSY
);

  // Issue counter is one bit wider so a full 2**AW burst fits.
  localparam int CW = AW + 1;

`ifdef RAM16X8_STREAM_READER_CSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
`endif

  state_t          state, state_nxt;
  logic [AW-1:0]   radr;
  logic [DW-1:0]   dout;
  logic            dout_val;
  logic            dout_last;
  logic [CW-1:0]   issue_cnt;

  logic            accept;     // command handshake in IDLE
  logic            load;       // fetch RDATA into the output register
  logic            finish;     // last beat handshaken in DRAIN
  logic            abort_hit;  // ABORT seen outside IDLE
`ifdef RAM16X8_STREAM_READER_CSUM_EN
  logic [DW-1:0]   csum;
  logic            csum_beat;  // present the checksum beat
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked state is always assigned with <= so every register in
      // the design samples the pre-edge values of its neighbours.
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    abort_hit = 1'b0;
`ifdef RAM16X8_STREAM_READER_CSUM_EN
    csum_beat = 1'b0;
`endif

    // ABORT outranks any fetch or handshake in the same cycle.
    if (ABORT && (state != S_IDLE)) begin
      abort_hit = 1'b1;
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (CMD_VAL) begin
            accept    = 1'b1;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          // Fetch when the output register is empty or being drained now.
          load = (issue_cnt != '0) && (!dout_val || DOUT_RDY);
          if (load && (issue_cnt == CW'(1))) begin
`ifdef RAM16X8_STREAM_READER_CSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DRAIN;
`endif
          end
        end
`ifdef RAM16X8_STREAM_READER_CSUM_EN
        S_CSUM: begin
          // Checksum beat replaces the final data beat once that one leaves.
          if (!dout_val || DOUT_RDY) begin
            csum_beat = 1'b1;
            state_nxt = S_DRAIN;
          end
        end
`endif
        S_DRAIN: begin
          if (dout_val && DOUT_RDY && dout_last) begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: address walker, issue counter and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      radr      <= '0;
      dout      <= '0;
      dout_val  <= 1'b0;
      dout_last <= 1'b0;
      issue_cnt <= '0;
`ifdef RAM16X8_STREAM_READER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (accept) begin
        radr      <= CMD_ADDR;
        issue_cnt <= (CMD_LEN == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, CMD_LEN};
`ifdef RAM16X8_STREAM_READER_CSUM_EN
        csum      <= '0;
`endif
      end

      if (abort_hit) begin
        // DOUT deliberately keeps its last value.
        dout_val  <= 1'b0;
        dout_last <= 1'b0;
        issue_cnt <= '0;
`ifdef RAM16X8_STREAM_READER_CSUM_EN
        csum      <= '0;
`endif
      end else if (load) begin
        // RDATA is sampled at this edge: a same-cycle write to radr is not
        // visible yet, which matches the RAM's asynchronous read.
        dout      <= RDATA;
        dout_val  <= 1'b1;
`ifdef RAM16X8_STREAM_READER_CSUM_EN
        dout_last <= 1'b0;
        csum      <= csum ^ RDATA;
`else
        dout_last <= (issue_cnt == CW'(1));
`endif
        radr      <= radr + AW'(1);  // natural modulo-2**AW wrap
        issue_cnt <= issue_cnt - CW'(1);
`ifdef RAM16X8_STREAM_READER_CSUM_EN
      end else if (csum_beat) begin
        dout      <= csum;
        dout_val  <= 1'b1;
        dout_last <= 1'b1;
`endif
      end else if (finish) begin
        dout_val  <= 1'b0;
        dout_last <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RADR      = radr;
  assign DOUT      = dout;
  assign DOUT_VAL  = dout_val;
  assign DOUT_LAST = dout_last;
  assign CMD_RDY   = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);

endmodule

// File: doc/ram16x8_stream_reader.md
Name: ram16x8_stream_reader

Overview:
- Read-side engine for a 16x8 distributed RAM with synchronous write and asynchronous read.
- Accepts a burst command (start address, length) and walks the RAM read address with modulo-16 wrap.
- Streams the bytes out on a valid/ready interface at up to one byte per cycle.
- Sits between the RAM read port and downstream consumers such as the UART/packet formatters; the write side is owned elsewhere.

Parameters:
- AW, 4, address width; RAM depth is 2**AW.
- DW, 8, data width.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CMD_VAL  input  1  command valid.
- CMD_RDY  output  1  command ready; high only in IDLE.
- CMD_ADDR  input  AW  burst start address.
- CMD_LEN  input  AW  burst length; 0 encodes 2**AW (16).
- ABORT  input  1  synchronous burst cancel.
- RADR  output  AW  RAM read address, driven from a register.
- RDATA  input  DW  RAM combinational read data.
- DOUT  output  DW  stream data.
- DOUT_VAL  output  1  stream valid.
- DOUT_RDY  input  1  stream ready.
- DOUT_LAST  output  1  marks the final beat of a burst.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE.
  - RADR=0, DOUT=0, DOUT_VAL=0, DOUT_LAST=0, BUSY=0, CMD_RDY=1.
  - Remaining and issued counters cleared.
- States: IDLE, RUN, DRAIN (plus CSUM when the optional feature is compiled in).
- Command accept (IDLE): on CMD_VAL&CMD_RDY:
  - RADR<=CMD_ADDR.
  - issue count<=CMD_LEN (0 maps to 16; counter is AW+1 bits).
  - -> RUN.
- Fetch rule (RUN): load = issue_cnt>0 && (!DOUT_VAL || DOUT_RDY). On load:
  - DOUT<=RDATA.
  - DOUT_VAL<=1.
  - DOUT_LAST<=(issue_cnt==1).
  - RADR<=RADR+1, wrapping 15->0.
  - issue_cnt decrements.
- Latency and throughput:
  - First DOUT_VAL is asserted 2 cycles after the command-accept edge: accept edge, then RUN cycle 1 samples RDATA.
  - Sustained rate is 1 beat/cycle while DOUT_RDY=1.
- Backpressure: when DOUT_VAL&!DOUT_RDY, DOUT, DOUT_LAST and RADR hold stable and no fetch occurs.
- Last issue: when issue_cnt reaches 0 -> DRAIN.
- DRAIN: on DOUT_VAL&DOUT_RDY with DOUT_LAST=1:
  - DOUT_VAL<=0, DOUT_LAST<=0.
  - -> IDLE; CMD_RDY rises the following cycle.
- Back-to-back bursts: no overlap. The next command is accepted at the earliest 1 cycle after the last beat handshake.
- ABORT (any non-IDLE state) takes priority over load/handshake:
  - DOUT_VAL<=0, DOUT_LAST<=0, issue_cnt<=0.
  - -> IDLE. DOUT keeps its last value.
  - ABORT in IDLE is ignored. A command presented in the same cycle as ABORT in IDLE is accepted normally.
- Length 16 from any start address reads every location exactly once and ends with RADR==start (full wrap).
- Write hazard: RAM contents are sampled at the load edge. A write to the current RADR in the same cycle returns pre-write data, per the RAM's async read. No coherency tracking.
- DOUT_VAL, once high, never drops without a handshake, except on ABORT or reset.

Optional Feature:
- Macro: RAM16X8_STREAM_READER_CSUM_EN.
- With the macro defined:
  - A running XOR of all data beats is kept.
  - After the data beat that would be LAST, state CSUM emits one extra beat, DOUT=XOR of all burst bytes, with DOUT_LAST=1.
  - On data beats, DOUT_LAST stays 0.
  - The checksum clears on command accept and on ABORT.
  - Burst length on the stream becomes len+1.
- Without the macro: no CSUM state or logic, and DOUT_LAST marks the final data beat.

Test Plan:
- RAM[0..15]=8'h10+i; CMD_ADDR=3, CMD_LEN=4, DOUT_RDY=1 -> DOUT 13,14,15,16 on consecutive cycles; first valid 2 cycles after accept; LAST on 16; CMD_RDY back 1 cycle later.
- CMD_ADDR=14, CMD_LEN=0 -> 16 beats 1E,1F,10..1D; wrap 15->0 correct; LAST on 1D; RADR==14 at end.
- CMD_ADDR=0, LEN=3; DOUT_RDY toggled 1,0,0,1,0,1 -> DOUT/DOUT_VAL stable while stalled; exactly 10,11,12 delivered, no duplicates or drops.
- ABORT asserted on the 2nd beat of LEN=8 -> next cycle DOUT_VAL=0, BUSY=0, CMD_RDY=1; a new command (ADDR=5, LEN=1) returns 15 with LAST.
- RST_N pulsed low mid-burst, asynchronously between edges -> all outputs at reset values immediately; no beats after release until a new command.
- CSUM_EN build: ADDR=0, LEN=2 with RAM[0]=A5, RAM[1]=0F -> beats A5, 0F, AA; LAST only on AA.
